// File: rtl/spi_flash_responder_pkg.sv
// Shared definitions for the SPI flash responder and its controller:
// opcodes, status bit positions and the command FSM encoding.
package spi_flash_pkg;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam int ST_WIP = 0;
  localparam int ST_WEL = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA_RD, S_DATA_WR, S_STATUS, S_IGNORE
  } fsm_state_e;

  typedef enum logic [1:0] {PEND_NONE, PEND_WREN, PEND_WRDI} pend_e;

  function automatic logic [7:0] status_byte(input logic wel_b, input logic wip_b);
    logic [7:0] s;
    s         = '0;
    s[ST_WEL] = wel_b;
    s[ST_WIP] = wip_b;
    return s;
  endfunction
endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pin bundle between a flash master and the responder.
interface spi_flash_responder_if;
  logic spi_clk;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, spi_cs, spi_mosi, input spi_miso);
  modport slave  (input spi_clk, spi_cs, spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_flash_responder_shifter.sv
// SPI mode-0 slave front end: pin synchronisers, edge detect, byte
// assembly on rising edges and MSB-first shift-out on falling edges.
module spi_slave_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       cs_high,
  output logic       cs_rise,
  output logic       bit_tick,
  output logic       rx_byte_valid,
  output logic [7:0] rx_byte,
  input  logic       tx_byte_load,
  input  logic [7:0] tx_byte
);
  logic [2:0] sclk_q, sclk_d, cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d;
  logic       miso_q, miso_d;
  logic       fall_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      bcnt_q <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
      miso_q <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      cs_q   <= cs_d;
      mosi_q <= mosi_d;
      bcnt_q <= bcnt_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      miso_q <= miso_d;
    end
  end

  // Edges are gated by the previous cs sample so a bit arriving together
  // with the cs rise still completes its byte.
  always_comb begin
    sclk_d        = {sclk_q[1:0], spi_clk};
    cs_d          = {cs_q[1:0], spi_cs};
    mosi_d        = {mosi_q[0], spi_mosi};
    cs_high       = cs_q[1];
    cs_rise       = cs_q[1] & ~cs_q[2];
    bit_tick      = sclk_q[1] & ~sclk_q[2] & ~cs_q[2];
    fall_tick     = ~sclk_q[1] & sclk_q[2] & ~cs_q[2];
    rx_byte       = {rx_q[6:0], mosi_q[1]};
    rx_byte_valid = 1'b0;
    bcnt_d        = bcnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    miso_d        = miso_q;
    if (bit_tick) begin
      rx_d          = rx_byte;
      bcnt_d        = bcnt_q + 3'd1;
      rx_byte_valid = (bcnt_q == 3'd7);
    end else if (cs_high) begin
      bcnt_d = '0;
    end
    if (fall_tick) begin
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end
    if (tx_byte_load) tx_d = tx_byte;
    if (cs_high) begin
      tx_d   = '0;
      miso_d = 1'b0;
    end
  end

  assign spi_miso = miso_q;
endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash/EEPROM responder: command FSM, address counter, write-in-progress
// timer and a byte array that powers up as all-FF.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int WRITE_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_flash_responder_if.slave  spi,
  output logic                  wip,
  output logic                  wel
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(WRITE_CYCLES + 1);

  logic [7:0] mem [DEPTH] = '{default: 8'hFF};

  fsm_state_e    state_q, state_d;
  pend_e         pend_q, pend_d;
  logic          wrote_q, wrote_d, wr_cmd_q, wr_cmd_d;
  logic          wel_q, wel_d, wip_q, wip_d;
  logic [AW-1:0] addr_q, addr_d, next_addr, rd_addr, mem_wa;
  logic [7:0]    addr_hi_q, addr_hi_d, mem_wd, tx_byte, rx_byte;
  logic [15:0]   addr_full;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          mem_we, tx_load, rx_valid, bit_tick, cs_high, cs_rise;

  spi_slave_shifter u_shifter (
    .clk          (clk),
    .reset        (reset),
    .spi_clk      (spi.spi_clk),
    .spi_cs       (spi.spi_cs),
    .spi_mosi     (spi.spi_mosi),
    .spi_miso     (spi.spi_miso),
    .cs_high      (cs_high),
    .cs_rise      (cs_rise),
    .bit_tick     (bit_tick),
    .rx_byte_valid(rx_valid),
    .rx_byte      (rx_byte),
    .tx_byte_load (tx_load),
    .tx_byte      (tx_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pend_q    <= PEND_NONE;
      wrote_q   <= 1'b0;
      wr_cmd_q  <= 1'b0;
      wel_q     <= 1'b0;
      wip_q     <= 1'b0;
      addr_q    <= '0;
      addr_hi_q <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      wrote_q   <= wrote_d;
      wr_cmd_q  <= wr_cmd_d;
      wel_q     <= wel_d;
      wip_q     <= wip_d;
      addr_q    <= addr_d;
      addr_hi_q <= addr_hi_d;
      tmr_q     <= tmr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    wrote_d   = wrote_q;
    wr_cmd_d  = wr_cmd_q;
    wel_d     = wel_q;
    wip_d     = wip_q;
    addr_d    = addr_q;
    addr_hi_d = addr_hi_q;
    tmr_d     = tmr_q;
    mem_we    = 1'b0;
    mem_wa    = addr_q;
    mem_wd    = rx_byte;
    tx_load   = 1'b0;
    addr_full = {addr_hi_q, rx_byte};
    next_addr = addr_q + AW'(1);
    rd_addr   = next_addr;

    if (wip_q) begin
      if (tmr_q == '0) wip_d = 1'b0;
      else             tmr_d = tmr_q - TW'(1);
    end

    case (state_q)
      S_IDLE:    if (!cs_high) state_d = S_CMD;
      S_CMD: if (rx_valid) begin
        state_d = S_IGNORE;
        case (rx_byte)
          OP_RDSR:  begin state_d = S_STATUS; tx_load = 1'b1; end
          OP_WREN:  if (!wip_q) pend_d = PEND_WREN;
          OP_WRDI:  if (!wip_q) pend_d = PEND_WRDI;
          OP_READ:  if (!wip_q) state_d = S_ADDR_HI;
          OP_WRITE: if (!wip_q && wel_q) begin state_d = S_ADDR_HI; wr_cmd_d = 1'b1; end
          default:  ;
        endcase
      end
      S_ADDR_HI: if (rx_valid) begin addr_hi_d = rx_byte; state_d = S_ADDR_LO; end
      S_ADDR_LO: if (rx_valid) begin
        addr_d  = addr_full[AW-1:0];
        rd_addr = addr_full[AW-1:0];
        if (wr_cmd_q) state_d = S_DATA_WR;
        else begin state_d = S_DATA_RD; tx_load = 1'b1; end
      end
      S_DATA_RD: if (rx_valid) begin addr_d = next_addr; tx_load = 1'b1; end
      S_DATA_WR: if (rx_valid) begin
        mem_we  = 1'b1;
        addr_d  = next_addr;
        wrote_d = 1'b1;
      end
      S_STATUS:  if (rx_valid) tx_load = 1'b1;
      S_IGNORE:  if (bit_tick) pend_d = PEND_NONE;
      default:   state_d = S_IDLE;
    endcase

    // Status bytes carry the live flags; read data comes straight off the array.
    tx_byte = (state_q == S_CMD || state_q == S_STATUS) ? status_byte(wel_q, wip_q)
                                                        : mem[rd_addr];

    // cs-rise actions see this cycle's byte outcome (pend_d, wrote_d) first.
    if (cs_rise) begin
      if (pend_d == PEND_WREN)      wel_d = 1'b1;
      else if (pend_d == PEND_WRDI) wel_d = 1'b0;
      if (wr_cmd_d) begin
        wel_d = 1'b0;
        if (wrote_d) begin
          wip_d = 1'b1;
          tmr_d = TW'(WRITE_CYCLES - 1);
        end
      end
    end
    if (cs_high) begin
      state_d  = S_IDLE;
      pend_d   = PEND_NONE;
      wrote_d  = 1'b0;
      wr_cmd_d = 1'b0;
    end
  end

  assign wip = wip_q;
  assign wel = wel_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench: SPI master BFM at clk/8 drives table vectors and a few
// hand-written sequences (status during write, ignore during wip, reset mid-transfer).
module tb_spi_flash_responder;
  localparam int WC = 200;

  logic clk, reset, wip, wel;
  spi_flash_responder_if spi();

  spi_flash_responder #(.DEPTH(512), .WRITE_CYCLES(WC)) dut (
    .clk  (clk),
    .reset(reset),
    .spi  (spi),
    .wip  (wip),
    .wel  (wel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [39:0] tx;
    int          nbits;
    int          rx_n;
    logic [15:0] rx_exp;
    logic        wel_exp;
    int          pulses;
  } vec_t;

  vec_t       vecs [17];
  logic [7:0] txb [16];
  logic [7:0] rxb [16];
  int         errors = 0, checks = 0;
  int         wip_rises = 0, wip_run = 0, wip_len = 0;
  logic       wip_d1 = 1'b0, miso_seen = 1'b0;

  always @(negedge clk) begin
    if (wip && !wip_d1) wip_rises++;
    if (wip) wip_run++;
    else if (wip_d1) begin wip_len = wip_run; wip_run = 0; end
    if (spi.spi_miso) miso_seen = 1'b1;
    wip_d1 = wip;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_tx(input logic [39:0] t);
    for (int k = 0; k < 16; k++) txb[k] = 8'h00;
    for (int k = 0; k < 5; k++) txb[k] = t[39-8*k -: 8];
  endtask

  task automatic xfer(input int nbits, input bit keep_cs);
    for (int k = 0; k < 16; k++) rxb[k] = 8'h00;
    spi.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.spi_mosi = txb[i/8][7-(i%8)];
      repeat (4) @(negedge clk);
      spi.spi_clk = 1'b1;
      rxb[i/8][7-(i%8)] = spi.spi_miso;
      repeat (4) @(negedge clk);
      spi.spi_clk = 1'b0;
    end
    if (!keep_cs) begin
      repeat (4) @(negedge clk);
      spi.spi_cs   = 1'b1;
      spi.spi_mosi = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send(input logic [39:0] t, input int nbits);
    set_tx(t);
    xfer(nbits, 1'b0);
  endtask

  // Bounded RDSR poll; an expired bound is reported as a failed check.
  task automatic poll_rdsr(input string name);
    logic [7:0] st;
    st = 8'hFF;
    for (int n = 0; n < 20 && st != 8'h00; n++) begin
      send(40'h05_00_00_00_00, 16);
      st = rxb[1];
    end
    check({name, "_poll"}, {8'h00, st}, 16'h0000);
  endtask

  initial begin
    int r0;
    vecs[0]  = '{"wren1",      40'h06_00_00_00_00,  8, 0, 16'h0000, 1'b1, 0};
    vecs[1]  = '{"rdsr_wel",   40'h05_00_00_00_00, 32, 1, 16'h0002, 1'b1, 0};
    vecs[2]  = '{"wr_01aa",    40'h02_01_AA_55_00, 32, 0, 16'h0000, 1'b0, 1};
    vecs[3]  = '{"rd_01aa",    40'h03_01_AA_00_00, 32, 1, 16'h0055, 1'b0, 0};
    vecs[4]  = '{"wr_nowren",  40'h02_00_10_AA_00, 32, 0, 16'h0000, 1'b0, 0};
    vecs[5]  = '{"rd_0010",    40'h03_00_10_00_00, 32, 1, 16'h00FF, 1'b0, 0};
    vecs[6]  = '{"wren2",      40'h06_00_00_00_00,  8, 0, 16'h0000, 1'b1, 0};
    vecs[7]  = '{"wrdi",       40'h04_00_00_00_00,  8, 0, 16'h0000, 1'b0, 0};
    vecs[8]  = '{"wren_9bit",  40'h06_80_00_00_00,  9, 0, 16'h0000, 1'b0, 0};
    vecs[9]  = '{"wren3",      40'h06_00_00_00_00,  8, 0, 16'h0000, 1'b1, 0};
    vecs[10] = '{"wr_wrap",    40'h02_01_FF_A1_A2, 40, 0, 16'h0000, 1'b0, 1};
    vecs[11] = '{"rd_01ff",    40'h03_01_FF_00_00, 40, 2, 16'hA1A2, 1'b0, 0};
    vecs[12] = '{"rd_0000",    40'h03_00_00_00_00, 32, 1, 16'h00A2, 1'b0, 0};
    vecs[13] = '{"wren4",      40'h06_00_00_00_00,  8, 0, 16'h0000, 1'b1, 0};
    vecs[14] = '{"wr_partial", 40'h02_00_20_F0_00, 29, 0, 16'h0000, 1'b0, 0};
    vecs[15] = '{"rd_0020",    40'h03_00_20_00_00, 32, 1, 16'h00FF, 1'b0, 0};
    vecs[16] = '{"rd_01aa_2",  40'h03_01_AA_00_00, 32, 1, 16'h0055, 1'b0, 0};

    reset = 1'b0; spi.spi_clk = 1'b0; spi.spi_cs = 1'b1; spi.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", {15'h0, spi.spi_miso}, 16'h0);
    check("rst_wip",  {15'h0, wip}, 16'h0);
    check("rst_wel",  {15'h0, wel}, 16'h0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) begin
      r0 = wip_rises;
      send(vecs[i].tx, vecs[i].nbits);
      if (vecs[i].pulses > 0) poll_rdsr(vecs[i].name);
      check({vecs[i].name, "_wel"}, {15'h0, wel}, {15'h0, vecs[i].wel_exp});
      check({vecs[i].name, "_wip_pulses"}, 16'(wip_rises - r0), 16'(vecs[i].pulses));
      if (vecs[i].pulses > 0) check({vecs[i].name, "_wip_len"}, 16'(wip_len), 16'(WC));
      if (vecs[i].rx_n == 1) check({vecs[i].name, "_data"}, {8'h00, rxb[3]}, vecs[i].rx_exp);
      if (vecs[i].rx_n == 2) check({vecs[i].name, "_data"}, {rxb[3], rxb[4]}, vecs[i].rx_exp);
    end

    // status streamed while the write timer runs
    send(40'h06_00_00_00_00, 8);
    send(40'h02_00_30_5A_00, 32);
    send(40'h05_00_00_00_00, 24);
    check("rdsr_busy0", {8'h00, rxb[1]}, 16'h0001);
    check("rdsr_busy1", {8'h00, rxb[2]}, 16'h0001);
    poll_rdsr("rdsr_busy");
    check("busy_wip_len", 16'(wip_len), 16'(WC));

    // WREN and READ issued during wip are ignored
    send(40'h06_00_00_00_00, 8);
    send(40'h02_00_31_5B_00, 32);
    send(40'h06_00_00_00_00, 8);
    check("wren_in_wip", {15'h0, wel}, 16'h0);
    miso_seen = 1'b0;
    send(40'h03_00_31_00_00, 32);
    check("rd_in_wip_data", {rxb[2], rxb[3]}, 16'h0000);
    check("rd_in_wip_miso", {15'h0, miso_seen}, 16'h0);
    poll_rdsr("ign");
    check("ign_wel", {15'h0, wel}, 16'h0);
    send(40'h03_00_31_00_00, 32);
    check("rd_0031", {8'h00, rxb[3]}, 16'h005B);

    // asynchronous reset in the middle of a READ address
    send(40'h06_00_00_00_00, 8);
    check("pre_rst_wel", {15'h0, wel}, 16'h1);
    set_tx(40'h03_01_AA_00_00);
    xfer(12, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_miso", {15'h0, spi.spi_miso}, 16'h0);
    check("mid_rst_wip",  {15'h0, wip}, 16'h0);
    check("mid_rst_wel",  {15'h0, wel}, 16'h0);
    spi.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    send(40'h03_01_AA_00_00, 32);
    check("post_rst_rd", {8'h00, rxb[3]}, 16'h0055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
